// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target receiver
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        DATA     = 3'd3,
        DATA_ACK = 3'd4,
        IGNORE   = 3'd5
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - pin synchronizer, glitch filter and edge pulses for one I2C line
module i2c_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   samp;

    assign samp = sync[SYNC_STAGES-1];

    // Presets to 1 so a reset on an idle bus never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '1;
            cnt   <= '0;
            level <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line};
            rise <= 1'b0;
            fall <= 1'b0;
            if (samp != level) begin
                if (cnt == CW'(FILT_LEN - 1)) begin
                    level <= samp;
                    cnt   <= '0;
                    rise  <= samp;
                    fall  <= ~samp;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - I2C target receiver (write only) with address match and ACK
module i2c_slave_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       bus_start,
    output logic       bus_stop,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst_n(rst_n), .line(scl_i),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst_n(rst_n), .line(sda_i),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_t state;
    logic [7:0] shift;
    logic [7:0] shift_next;
    logic [2:0] bit_cnt;
    logic       ack_phase;
    logic       first_flag;
    logic       start_evt;
    logic       stop_evt;

    assign sda_o      = 1'b0;
    assign start_evt  = sda_fall & scl_lvl;
    assign stop_evt   = sda_rise & scl_lvl;
    assign shift_next = {shift[6:0], sda_lvl};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            ack_phase  <= 1'b0;
            first_flag <= 1'b0;
            sda_t      <= I2C_NACK;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            bus_start  <= 1'b0;
            bus_stop   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            bus_start <= 1'b0;
            bus_stop  <= 1'b0;
            // Bus conditions win over any SCL edge seen in the same cycle.
            if (start_evt) begin
                state     <= ADDR;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_t     <= I2C_NACK;
                bus_start <= 1'b1;
                busy      <= 1'b1;
            end else if (stop_evt) begin
                state     <= IDLE;
                bit_cnt   <= '0;
                ack_phase <= 1'b0;
                sda_t     <= I2C_NACK;
                bus_stop  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift   <= shift_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ADDR) begin
                                    if (shift[6:0] == SLAVE_ADDR && sda_lvl == I2C_RW_WRITE)
                                        state <= ADDR_ACK;
                                    else
                                        state <= IGNORE;
                                end else begin
                                    rx_data    <= shift_next;
                                    rx_valid   <= 1'b1;
                                    rx_first   <= first_flag;
                                    first_flag <= 1'b0;
                                    state      <= DATA_ACK;
                                end
                            end
                        end
                    end
                    ADDR_ACK, DATA_ACK: begin
                        // First fall ends bit 8 and starts the ACK; second fall ends the 9th clock.
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                sda_t     <= I2C_ACK;
                                ack_phase <= 1'b1;
                            end else begin
                                sda_t     <= I2C_NACK;
                                ack_phase <= 1'b0;
                                state     <= DATA;
                                if (state == ADDR_ACK)
                                    first_flag <= 1'b1;
                            end
                        end
                    end
                    IGNORE: begin
                        sda_t <= I2C_NACK;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - directed bench: I2C master model driving the target through a pull-up
module tb_i2c_slave_rx;

    localparam int QTR = 10;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    wire        sda_line;
    logic       sda_o, sda_t;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first, bus_start, bus_stop, busy;

    assign sda_line = sda_drv & (sda_t | sda_o);

    i2c_slave_rx dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_drv), .sda_i(sda_line),
        .sda_o(sda_o), .sda_t(sda_t), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_first(rx_first), .bus_start(bus_start), .bus_stop(bus_stop), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int rx_cnt = 0, start_cnt = 0, stop_cnt = 0, sdat_low = 0;
    logic [7:0] log_data  [16];
    logic       log_first [16];

    always @(negedge clk) begin
        if (rx_valid) begin
            log_data[rx_cnt & 15]  = rx_data;
            log_first[rx_cnt & 15] = rx_first;
            rx_cnt++;
        end
        if (bus_start) start_cnt++;
        if (bus_stop)  stop_cnt++;
        if (!sda_t)    sdat_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; q();
        scl_drv = 1'b1; q();
        sda_drv = 1'b0; q();
        scl_drv = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; q();
        scl_drv = 1'b1; q();
        sda_drv = 1'b1; q();
    endtask

    task automatic send_bit(input logic b);
        sda_drv = b;    q();
        scl_drv = 1'b1; q(); q();
        scl_drv = 1'b0; q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked, output logic released);
        logic a1, a2;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_drv = 1'b1; q();
        scl_drv = 1'b1; q();
        a1 = (sda_line == 1'b0); q();
        a2 = (sda_line == 1'b0);
        scl_drv = 1'b0; q();
        released = sda_t;
        acked = a1 & a2;
    endtask

    int   r0, s0, p0, l0;
    logic ack, rel;
    logic [7:0] gb;

    initial begin
        idle(5);
        chk("rst_sda_t", sda_t, 1);
        chk("rst_sda_o", sda_o, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_first", rx_first, 0);
        chk("rst_start_stop", {bus_start, bus_stop}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle(20);
        chk("post_rst_busy", busy, 0);

        // 1: single accepted byte
        r0 = rx_cnt; s0 = start_cnt; p0 = stop_cnt;
        i2c_start();
        chk("t1_busy", busy, 1);
        send_byte(8'h84, ack, rel);
        chk("t1_addr_ack", ack, 1);
        chk("t1_addr_rel", rel, 1);
        send_byte(8'hA5, ack, rel);
        chk("t1_data_ack", ack, 1);
        chk("t1_data_rel", rel, 1);
        i2c_stop();
        idle(20);
        chk("t1_rx_cnt", rx_cnt - r0, 1);
        chk("t1_rx_data", log_data[r0 & 15], 8'hA5);
        chk("t1_rx_first", log_first[r0 & 15], 1);
        chk("t1_starts", start_cnt - s0, 1);
        chk("t1_stops", stop_cnt - p0, 1);
        chk("t1_busy_end", busy, 0);

        // 2: other address is ignored
        r0 = rx_cnt; p0 = stop_cnt; l0 = sdat_low;
        i2c_start();
        send_byte(8'h86, ack, rel);
        chk("t2_addr_nack", ack, 0);
        send_byte(8'hA5, ack, rel);
        i2c_stop();
        idle(20);
        chk("t2_sda_t_low", sdat_low - l0, 0);
        chk("t2_rx_cnt", rx_cnt - r0, 0);
        chk("t2_stops", stop_cnt - p0, 1);

        // 3: read request to our address is NACKed
        r0 = rx_cnt;
        i2c_start();
        send_byte(8'h85, ack, rel);
        chk("t3_read_nack", ack, 0);
        i2c_stop();
        idle(20);
        chk("t3_rx_cnt", rx_cnt - r0, 0);

        // 4: three data bytes in one frame
        r0 = rx_cnt;
        i2c_start();
        send_byte(8'h84, ack, rel);
        send_byte(8'h12, ack, rel);
        send_byte(8'h34, ack, rel);
        send_byte(8'h56, ack, rel);
        chk("t4_last_ack", ack, 1);
        i2c_stop();
        idle(20);
        chk("t4_rx_cnt", rx_cnt - r0, 3);
        chk("t4_d0", {log_first[r0 & 15], log_data[r0 & 15]}, 9'h112);
        chk("t4_d1", {log_first[(r0 + 1) & 15], log_data[(r0 + 1) & 15]}, 9'h034);
        chk("t4_d2", {log_first[(r0 + 2) & 15], log_data[(r0 + 2) & 15]}, 9'h056);

        // 5: repeated START restarts the first-byte flag
        r0 = rx_cnt; s0 = start_cnt;
        i2c_start();
        send_byte(8'h84, ack, rel);
        send_byte(8'h12, ack, rel);
        i2c_start();
        send_byte(8'h84, ack, rel);
        chk("t5_sr_addr_ack", ack, 1);
        send_byte(8'h77, ack, rel);
        i2c_stop();
        idle(20);
        chk("t5_starts", start_cnt - s0, 2);
        chk("t5_rx_cnt", rx_cnt - r0, 2);
        chk("t5_d0", {log_first[r0 & 15], log_data[r0 & 15]}, 9'h112);
        chk("t5_d1", {log_first[(r0 + 1) & 15], log_data[(r0 + 1) & 15]}, 9'h177);

        // 6a: SDA glitches shorter than the filter are invisible
        s0 = start_cnt; p0 = stop_cnt;
        sda_drv = 1'b0; @(negedge clk); sda_drv = 1'b1;
        idle(20);
        sda_drv = 1'b0; idle(2); sda_drv = 1'b1;
        idle(20);
        chk("t6_glitch_start", start_cnt - s0, 0);
        chk("t6_glitch_stop", stop_cnt - p0, 0);
        chk("t6_glitch_busy", busy, 0);
        sda_drv = 1'b0; idle(3); sda_drv = 1'b1;
        idle(20);
        chk("t6_filt_len_start", start_cnt - s0, 1);
        chk("t6_filt_len_stop", stop_cnt - p0, 1);

        // 6b: reset asserted while the data ACK is being driven
        i2c_start();
        send_byte(8'h84, ack, rel);
        gb = 8'hC3;
        for (int i = 7; i >= 0; i--) send_bit(gb[i]);
        sda_drv = 1'b1; q();
        scl_drv = 1'b1; q();
        chk("t6_ack_driven", sda_t, 0);
        r0 = rx_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sda_t", sda_t, 1);
        chk("t6_rst_rx_data", rx_data, 0);
        chk("t6_rst_busy", busy, 0);
        idle(2);
        rst_n = 1'b1;
        l0 = sdat_low;
        q();
        scl_drv = 1'b0; q();
        send_byte(8'h5A, ack, rel);
        chk("t6_after_rst_nack", ack, 0);
        i2c_stop();
        idle(20);
        chk("t6_after_rst_rx", rx_cnt - r0, 0);
        chk("t6_after_rst_sda_t", sdat_low - l0, 0);
        chk("t6_after_rst_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
